uart_rx_frame_parser: RTL

- Sits directly downstream of the UART receiver and consumes its byte stream (rx_data/rx_ready).
- Assembles command frames from the host PC: SOF, CMD, LEN, payload, XOR checksum.
- Buffers the payload and presents one validated frame at a time to the game/control logic over a valid/ack handshake. Default payload size fits a full 81-cell sudoku grid.

---
 rtl/comm_pkg.sv | 20 ++
 rtl/rx_payload_ram.sv | 35 +++
 rtl/uart_rx_frame_parser.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// Shared constants for the host command link: framing byte, parser state codes,
// command codes and the frame length / payload address width.
`timescale 1ns/1ps
package comm_pkg;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;
    localparam int         FLEN_W       = 7;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;

    localparam logic [7:0] CMD_LOAD_GRID  = 8'h57;
    localparam logic [7:0] CMD_RESET_GAME = 8'h52;
    localparam logic [7:0] CMD_QUERY      = 8'h51;

endpackage

// File: rtl/rx_payload_ram.sv
// Payload buffer: DEPTH x 8 simple dual-port, synchronous write, registered read.
// Read latency 1 cycle; no backpressure, out-of-range reads return 0.
`timescale 1ns/1ps
module rx_payload_ram
    import comm_pkg::*;
#(
    parameter int DEPTH = 81
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_vld,
    input  logic [FLEN_W-1:0] wr_addr,
    input  logic [7:0]        wr_dat,
    input  logic [FLEN_W-1:0] rd_addr,
    output logic [7:0]        rd_dat
);

    logic [7:0] mem [0:DEPTH-1];

    // Storage is deliberately left out of reset; only the read register clears.
    always_ff @(posedge clock) begin
        if (wr_vld && (wr_addr < FLEN_W'(DEPTH)))
            mem[wr_addr] <= wr_dat;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rd_dat <= 8'h00;
        else if (rd_addr < FLEN_W'(DEPTH))
            rd_dat <= mem[rd_addr];
        else
            rd_dat <= 8'h00;
    end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser: SOF/CMD/LEN/payload/XOR-checksum from UART bytes; optional inter-byte timeout (UART_RX_FRAME_PARSER_TIMEOUT_EN).
// Latency: frame_valid the cycle after the checksum byte; payload read 1 cycle.
// Backpressure: none upstream; bytes arriving while a frame is held are dropped with err_overrun.
`timescale 1ns/1ps
module uart_rx_frame_parser
    import comm_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE     = SOF_BYTE_DEF,
    parameter int          MAX_PAYLOAD  = 81,
    parameter int          TIMEOUT_CLKS = 21700
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [FLEN_W-1:0] frame_len,
    input  logic [FLEN_W-1:0] payload_rd_addr,
    output logic [7:0]        payload_rd_data,
    input  logic              frame_ack,
    output logic              err_checksum,
    output logic              err_length,
    output logic              err_overrun,
    output logic              err_timeout
);

    if (TIMEOUT_CLKS < 2 || TIMEOUT_CLKS > 32768) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must fit the 15-bit inter-byte counter");
    end

    logic [2:0]        state;
    logic [7:0]        chk;
    logic [FLEN_W-1:0] idx;
    logic              to_hit;

    assign frame_valid = (state == ST_HOLD);

`ifdef UART_RX_FRAME_PARSER_TIMEOUT_EN
    localparam logic [14:0] TO_LAST = 15'(TIMEOUT_CLKS - 1);
    logic [14:0] to_cnt;
    logic        err_timeout_q;
    logic        in_frame;

    assign in_frame    = (state == ST_CMD) || (state == ST_LEN) ||
                         (state == ST_PAYLOAD) || (state == ST_CHK);
    assign to_hit      = in_frame && !rx_ready && (to_cnt == TO_LAST);
    assign err_timeout = err_timeout_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= to_hit;
            if (rx_ready || !in_frame || to_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 15'd1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            chk          <= 8'h00;
            idx          <= '0;
            frame_cmd    <= 8'h00;
            frame_len    <= '0;
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_overrun  <= 1'b0;
            if (to_hit) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_ready && rx_data == SOF_BYTE)
                            state <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (rx_ready) begin
                            frame_cmd <= rx_data;
                            chk       <= rx_data;
                            state     <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_ready) begin
                            if (rx_data > 8'(MAX_PAYLOAD)) begin
                                err_length <= 1'b1;
                                state      <= ST_IDLE;
                            end else begin
                                frame_len <= rx_data[FLEN_W-1:0];
                                chk       <= chk ^ rx_data;
                                idx       <= '0;
                                state     <= (rx_data == 8'h00) ? ST_CHK : ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_ready) begin
                            chk <= chk ^ rx_data;
                            idx <= idx + 1'b1;
                            if (idx == frame_len - 1'b1)
                                state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (rx_ready) begin
                            if (rx_data == chk) begin
                                state <= ST_HOLD;
                            end else begin
                                err_checksum <= 1'b1;
                                state        <= ST_IDLE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // A byte racing the ack is still dropped and flagged.
                        if (rx_ready)
                            err_overrun <= 1'b1;
                        if (frame_ack)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    rx_payload_ram #(
        .DEPTH (MAX_PAYLOAD)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_vld  (rx_ready && (state == ST_PAYLOAD)),
        .wr_addr (idx),
        .wr_dat  (rx_data),
        .rd_addr (payload_rd_addr),
        .rd_dat  (payload_rd_data)
    );

endmodule
